// File: rtl/ram_stream_reader.sv
// Reads a block of words from RAM port B and streams them out through a small FIFO.
// Optional abort input is enabled by defining RAM_STREAM_READER_ABORT_EN.
module ram_stream_reader #(
    parameter int unsigned AWIDTH     = 10,
    parameter int unsigned DWIDTH     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
`ifdef RAM_STREAM_READER_ABORT_EN
    input  logic              abort,
`endif
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   length,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] ram_address_b,
    output logic              ram_rden_b,
    input  logic [DWIDTH-1:0] ram_out_b,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned LW = AWIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [LW-1:0]     rem_q, rem_d;
    logic              inflight_q, inflight_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DWIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DWIDTH-1:0] mem_d [FIFO_DEPTH];
    logic              ram_rden_b_q, ram_rden_b_d;
    logic [AWIDTH-1:0] ram_address_b_q, ram_address_b_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              out_valid_q, out_valid_d;
    logic              abort_w;
    logic              push;
    logic              pop;

`ifdef RAM_STREAM_READER_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Control, counters and FIFO bookkeeping; read enable is decided one cycle ahead
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        inflight_d      = ram_rden_b_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        mem_d           = mem_q;
        done_d          = 1'b0;
        push            = inflight_q;
        pop             = out_valid_q && out_ready;

        if (push) begin
            mem_d[wr_ptr_q] = ram_out_b;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        if (ram_rden_b_q) begin
            addr_d = addr_q + AWIDTH'(1);
            rem_d  = rem_q - LW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d = S_RUN;
                        addr_d  = base_addr;
                        rem_d   = length;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (ram_rden_b_q && (rem_q == LW'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!inflight_q && (count_d == '0)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort drops everything buffered or still coming back from the RAM
        if (abort_w && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            done_d     = 1'b0;
            inflight_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end

        ram_rden_b_d    = (state_d == S_RUN) &&
                          ((count_d + CW'(inflight_d)) < CW'(FIFO_DEPTH));
        ram_address_b_d = ram_rden_b_d ? addr_d : ram_address_b_q;
        busy_d          = (state_d != S_IDLE);
        out_valid_d     = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            ram_rden_b_q    <= 1'b0;
            ram_address_b_q <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            out_valid_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            inflight_q      <= inflight_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            ram_rden_b_q    <= ram_rden_b_d;
            ram_address_b_q <= ram_address_b_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            out_valid_q     <= out_valid_d;
        end
    end

    // Storage needs no reset; entries are only read while counted valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign ram_rden_b    = ram_rden_b_q;
    assign ram_address_b = ram_address_b_q;
    assign out_valid     = out_valid_q;
    assign out_data      = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: expected addresses and data are queued at
// stimulus time and checked by an independent negedge monitor.
module tb_ram_stream_reader;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned FD = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
`ifdef RAM_STREAM_READER_ABORT_EN
    logic          abort = 1'b0;
`endif
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, ram_rden_b, out_valid;
    logic [AW-1:0] ram_address_b;
    logic [DW-1:0] ram_out_b;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b1;

    logic [DW-1:0] ram [1<<AW];

    int errors = 0;
    int checks = 0;
    int rd_cnt = 0;
    int pop_cnt = 0;
    int done_cnt = 0;

    logic [DW-1:0] exp_data [$];
    logic [AW-1:0] exp_addr [$];

    ram_stream_reader #(.AWIDTH(AW), .DWIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
`ifdef RAM_STREAM_READER_ABORT_EN
        .abort        (abort),
`endif
        .base_addr    (base_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .ram_address_b(ram_address_b),
        .ram_rden_b   (ram_rden_b),
        .ram_out_b    (ram_out_b),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    // RAM port B: registered read, output held while not reading
    always @(posedge clk) begin
        if (ram_rden_b) ram_out_b <= ram[ram_address_b];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_stream(input logic [AW-1:0] base, input int len);
        logic [AW-1:0] a;
        start     = 1'b1;
        base_addr = base;
        length    = (AW+1)'(len);
        for (int i = 0; i < len; i++) begin
            a = base + AW'(i);
            exp_addr.push_back(a);
            exp_data.push_back(DW'(a));
        end
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        logic found;
        found = 1'b0;
        for (int k = 0; k < max_cycles; k++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        chk(name, 32'(found), 32'd1);
    endtask

    // Monitor: checks every issued address and every accepted word against the queues
    initial begin
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (resetn) begin
                if (ram_rden_b) begin
                    rd_cnt++;
                    if (exp_addr.size() == 0) fail_now("unexpected_read");
                    else begin
                        ea = exp_addr.pop_front();
                        chk("ram_address_b", 32'(ram_address_b), 32'(ea));
                    end
                end
                if (out_valid && out_ready) begin
                    pop_cnt++;
                    if (exp_data.size() == 0) fail_now("unexpected_word");
                    else begin
                        ed = exp_data.pop_front();
                        chk("out_data", out_data, ed);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int rd0, dc0, p0;
        logic [15:0] pat;

        for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i);

        // Reset state
        repeat (3) cyc();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rden", 32'(ram_rden_b), 0);
        chk("rst_addr", 32'(ram_address_b), 0);
        chk("rst_valid", 32'(out_valid), 0);
        resetn = 1'b1;
        cyc();

        // Back-to-back stream with timing of valid, busy and done
        rd0 = rd_cnt; dc0 = done_cnt;
        start_stream(10'h010, 8);
        for (int k = 0; k <= 11; k++) begin
            chk("t1_valid", 32'(out_valid), 32'((k >= 2) && (k <= 9)));
            chk("t1_done", 32'(done), 32'(k == 10));
            chk("t1_busy", 32'(busy), 32'(k < 10));
            cyc();
        end
        chk("t1_reads", 32'(rd_cnt - rd0), 8);
        chk("t1_done_cnt", 32'(done_cnt - dc0), 1);
        chk("t1_drained", 32'(exp_data.size()), 0);

        // Address wrap at the top of the RAM
        rd0 = rd_cnt;
        start_stream(10'h3FE, 4);
        wait_done("t2_done", 40);
        cyc();
        chk("t2_reads", 32'(rd_cnt - rd0), 4);
        chk("t2_drained", 32'(exp_data.size()), 0);

        // Backpressure: credit stops reads at FIFO depth; start ignored while busy
        rd0 = rd_cnt; dc0 = done_cnt;
        out_ready = 1'b0;
        start_stream(10'h020, 6);
        for (int k = 0; k < 20; k++) begin
            if (k == 10) begin
                start = 1'b1; base_addr = 10'h300; length = 11'd3;
            end else begin
                start = 1'b0;
            end
            cyc();
        end
        start = 1'b0;
        chk("t3_reads_stalled", 32'(rd_cnt - rd0), 4);
        chk("t3_rden_stalled", 32'(ram_rden_b), 0);
        chk("t3_valid_stalled", 32'(out_valid), 1);
        chk("t3_busy_stalled", 32'(busy), 1);
        out_ready = 1'b1;
        wait_done("t3_done", 40);
        cyc();
        chk("t3_reads", 32'(rd_cnt - rd0), 6);
        chk("t3_done_cnt", 32'(done_cnt - dc0), 1);
        chk("t3_drained", 32'(exp_data.size()), 0);

        // Zero length: immediate done, never busy, no reads
        rd0 = rd_cnt;
        start_stream(10'h055, 0);
        chk("t4_done", 32'(done), 1);
        chk("t4_busy", 32'(busy), 0);
        cyc();
        chk("t4_done_off", 32'(done), 0);
        chk("t4_busy2", 32'(busy), 0);
        cyc();
        chk("t4_reads", 32'(rd_cnt - rd0), 0);

        // Reset mid-stream after three words popped
        p0 = pop_cnt;
        start_stream(10'h040, 8);
        for (int k = 0; k < 50; k++) begin
            if (pop_cnt - p0 >= 3) break;
            cyc();
        end
        chk("t5_popped3", 32'(pop_cnt - p0), 3);
        resetn = 1'b0;
        exp_data.delete();
        exp_addr.delete();
        dc0 = done_cnt;
        cyc();
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        chk("t5_rden", 32'(ram_rden_b), 0);
        chk("t5_addr", 32'(ram_address_b), 0);
        chk("t5_valid", 32'(out_valid), 0);
        resetn = 1'b1;
        repeat (4) cyc();
        chk("t5_no_done", 32'(done_cnt - dc0), 0);
        chk("t5_idle_valid", 32'(out_valid), 0);
        rd0 = rd_cnt;
        start_stream(10'h100, 2);
        wait_done("t5_new_done", 30);
        cyc();
        chk("t5_new_reads", 32'(rd_cnt - rd0), 2);
        chk("t5_drained", 32'(exp_data.size()), 0);

        // Irregular consumer pattern
        rd0 = rd_cnt;
        pat = 16'b1011_0010_0111_0100;
        start_stream(10'h200, 10);
        begin
            logic found;
            found = 1'b0;
            for (int k = 0; k < 200; k++) begin
                out_ready = pat[k % 16];
                if (done) begin
                    found = 1'b1;
                    break;
                end
                cyc();
            end
            chk("t6_done", 32'(found), 1);
        end
        out_ready = 1'b1;
        cyc();
        chk("t6_reads", 32'(rd_cnt - rd0), 10);
        chk("t6_drained", 32'(exp_data.size()), 0);

`ifdef RAM_STREAM_READER_ABORT_EN
        // Abort with two words buffered
        rd0 = rd_cnt; dc0 = done_cnt;
        out_ready = 1'b0;
        start_stream(10'h080, 8);
        cyc(); cyc(); cyc();
        chk("t7_valid_before", 32'(out_valid), 1);
        abort = 1'b1;
        exp_data.delete();
        cyc();
        abort = 1'b0;
        exp_addr.delete();
        chk("t7_valid", 32'(out_valid), 0);
        chk("t7_busy", 32'(busy), 0);
        chk("t7_rden", 32'(ram_rden_b), 0);
        out_ready = 1'b1;
        repeat (5) cyc();
        chk("t7_reads", 32'(rd_cnt - rd0), 4);
        chk("t7_no_done", 32'(done_cnt - dc0), 0);
        chk("t7_idle_valid", 32'(out_valid), 0);
`endif

        repeat (2) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameters: AWIDTH, 10, RAM address width; DWIDTH, 32, data width; FIFO_DEPTH, 4, output buffer entries (power of 2, >=2).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock.
- resetn  in  1  reset: synchronous, active-low.
- start  in  1  begin stream (sampled in IDLE only).
- base_addr  in  AWIDTH  first word address.
- length  in  AWIDTH+1  words to read (0..2^AWIDTH).
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle completion pulse.
- ram_address_b  out  AWIDTH  to RAM port B address.
- ram_rden_b  out  1  to RAM port B read enable.
- ram_out_b  in  DWIDTH  RAM port B data, valid 1 cycle after rden_b.
- out_data  out  DWIDTH  stream data (FIFO head).
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.

Function
REQ-003 SHALL implement FSM IDLE, RUN, DRAIN.
REQ-004 IDLE: start=1, length!=0 -> latch base_addr into addr counter, length into remaining counter, go RUN; start=1, length=0 -> done=1 next cycle, stay IDLE.
REQ-005 start SHALL be ignored in RUN and DRAIN.
REQ-006 RUN: ram_rden_b=1 iff fifo_count + inflight < FIFO_DEPTH (inflight = read issued previous cycle, 0 or 1); ram_address_b = addr counter.
REQ-007 Each issued read SHALL increment addr (modulo 2^AWIDTH, wrap 2^AWIDTH-1 -> 0) and decrement remaining.
REQ-008 Issue of read with remaining=1 SHALL move FSM to DRAIN.
REQ-009 ram_out_b SHALL be written into FIFO exactly the cycle after an issued read; never otherwise (held RAM output while rden_b=0 is not re-captured).
REQ-010 ram_rden_b SHALL be 0 in IDLE and DRAIN; ram_address_b holds last value when not reading.
REQ-011 FIFO: out_valid = count!=0; pop when out_valid & out_ready; push and pop same cycle leaves count unchanged; push when full impossible by REQ-006 credit rule.
REQ-012 DRAIN -> IDLE when count=0 and inflight=0 (including pop in that cycle leaving empty); done=1 for one cycle on that transition, busy falls same cycle.
REQ-013 Data SHALL be delivered in address order, no loss or duplication, under any out_ready pattern.
REQ-014 Sustained throughput SHALL be 1 word/cycle with out_ready held 1; first out_valid 2 cycles after start sampled.

Reset
REQ-015 resetn=0 at clk edge SHALL force: FSM IDLE, busy=0, done=0, ram_rden_b=0, ram_address_b=0, out_valid=0, FIFO pointers/count=0, inflight=0, counters=0.
REQ-016 Reset mid-stream SHALL discard all buffered and in-flight data; no done pulse.

Configuration
REQ-017 Macro RAM_STREAM_READER_ABORT_EN: when defined, adds input abort (1 bit); abort=1 in RUN/DRAIN forces IDLE next cycle, flushes FIFO, discards in-flight read, out_valid=0 next cycle, no done; abort ignored in IDLE.
REQ-018 Without RAM_STREAM_READER_ABORT_EN: no abort port; stream runs to completion or reset only.

Verification
REQ-019 base_addr=0x010, length=8, out_ready=1, RAM word[i]=i -> out_data 0x10..0x17 on 8 consecutive cycles, done 1 cycle after last pop.
REQ-020 base_addr=0x3FE, length=4 -> ram_address_b 0x3FE,0x3FF,0x000,0x001; data in that order.
REQ-021 length=6, out_ready=0 for 20 cycles -> exactly 4 reads issued, count=4, ram_rden_b=0; release out_ready -> remaining 2 read, all 6 delivered in order.
REQ-022 length=0 with start -> done pulse next cycle, busy never 1, no ram_rden_b.
REQ-023 resetn=0 after 3 of 8 words popped -> all outputs at reset values next cycle; new start length=2 delivers only the 2 new words.
REQ-024 With RAM_STREAM_READER_ABORT_EN, abort in RUN with 2 words buffered -> IDLE, out_valid=0 next cycle, no done, no further rden_b.
